// File: rtl/sl_transmitter.sv
// sl_transmitter: serialises a parallel word onto the two active-low SL wires.
// Each bit is one low pulse (sl1_n low = '1', sl0_n low = '0'), LSB first, an
// optional odd-parity bit, then a stop pulse with both lines low. Every pulse is
// followed by a both-high gap.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous reset, active-low
//   tx_data_i      word to send, bit 0 first
//   tx_len_i       number of data bits, legal 8..32
//   tx_parity_en_i append odd-parity bit after the data
//   tx_valid_i     send request, accepted when tx_ready_o is high
//   tx_ready_o     high only while idle
//   sl0_n_o        zeroes line, active-low, registered
//   sl1_n_o        ones line, active-low, registered
//   busy_o         frame in progress
//   done_o         one-cycle pulse in the first idle cycle after a frame
//   len_err_o      one-cycle pulse after an accepted request with illegal length
module sl_transmitter #(
    parameter int unsigned PULSE_CYC = 16,
    parameter int unsigned GAP_CYC   = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tx_data_i,
    input  logic [5:0]  tx_len_i,
    input  logic        tx_parity_en_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        sl0_n_o,
    output logic        sl1_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        len_err_o
);

    typedef enum logic [2:0] {StIdle, StPulse, StGap, StStop, StSgap} state_e;

    localparam logic [CNT_W-1:0] PulseLd = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GapLd   = CNT_W'(GAP_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      shift_q, shift_d;
    logic [5:0]       bits_q, bits_d;
    logic             done_q, done_d;
    logic             len_err_q, len_err_d;
    logic             sl0_n_q, sl0_n_d;
    logic             sl1_n_q, sl1_n_d;

    logic        accept;
    logic        len_ok;
    logic [32:0] mask;
    logic [32:0] masked;
    logic        par_bit;
    logic [32:0] frame_bits;
    logic        cnt_zero;

    assign accept   = tx_valid_i && (state_q == StIdle);
    assign len_ok   = (tx_len_i >= 6'd8) && (tx_len_i <= 6'd32);
    assign cnt_zero = (cnt_q == '0);

    // Data bits above tx_len-1 are dropped; the parity bit lands at position tx_len
    // so the shift register simply walks through data then parity.
    always_comb begin
        mask       = (33'd1 << tx_len_i) - 33'd1;
        masked     = {1'b0, tx_data_i} & mask;
        par_bit    = ~(^masked);
        frame_bits = masked | (33'(tx_parity_en_i & par_bit) << tx_len_i);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bits_d    = bits_q;
        done_d    = 1'b0;
        len_err_d = accept && !len_ok;

        unique case (state_q)
            StIdle: begin
                if (accept && len_ok) begin
                    state_d = StPulse;
                    cnt_d   = PulseLd;
                    shift_d = frame_bits;
                    bits_d  = tx_len_i + 6'(tx_parity_en_i);
                end
            end
            StPulse: begin
                if (cnt_zero) begin
                    state_d = StGap;
                    cnt_d   = GapLd;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_zero) begin
                    cnt_d = PulseLd;
                    // bits_q counts the slot just sent as still remaining
                    if (bits_q > 6'd1) begin
                        state_d = StPulse;
                        shift_d = shift_q >> 1;
                        bits_d  = bits_q - 6'd1;
                    end else begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StStop: begin
                if (cnt_zero) begin
                    state_d = StSgap;
                    cnt_d   = GapLd;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StSgap: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lines follow the registered state one cycle later, so each line is a plain
    // flop and the first low edge appears one cycle after the accept edge.
    always_comb begin
        sl0_n_d = !(((state_q == StPulse) && !shift_q[0]) || (state_q == StStop));
        sl1_n_d = !(((state_q == StPulse) && shift_q[0]) || (state_q == StStop));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            bits_q    <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            sl0_n_q   <= 1'b1;
            sl1_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            sl0_n_q   <= sl0_n_d;
            sl1_n_q   <= sl1_n_d;
        end
    end

    assign tx_ready_o = (state_q == StIdle);
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign len_err_o  = len_err_q;
    assign sl0_n_o    = sl0_n_q;
    assign sl1_n_o    = sl1_n_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: per-cycle comparison of line/status outputs
// against a slot model computed from the requested word.
module tb_sl_transmitter;

    localparam int PULSE = 16;
    localparam int GAP   = 16;
    localparam int SLOT  = PULSE + GAP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tx_data;
    logic [5:0]  tx_len;
    logic        tx_parity_en;
    logic        tx_valid;
    logic        tx_ready;
    logic        sl0_n;
    logic        sl1_n;
    logic        busy;
    logic        done;
    logic        len_err;

    int n_vec = 0;
    int n_err = 0;

    sl_transmitter #(
        .PULSE_CYC(PULSE),
        .GAP_CYC  (GAP),
        .CNT_W    (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data_i     (tx_data),
        .tx_len_i      (tx_len),
        .tx_parity_en_i(tx_parity_en),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .sl0_n_o       (sl0_n),
        .sl1_n_o       (sl1_n),
        .busy_o        (busy),
        .done_o        (done),
        .len_err_o     (len_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed status: {sl1_n, sl0_n, busy, done, tx_ready, len_err}
    task automatic check(input string tag, input int cyc, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {sl1_n, sl0_n, busy, done, tx_ready, len_err};
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cyc %0d: observed {sl1,sl0,busy,done,rdy,lerr}=%b expected %b",
                   tag, cyc, obs, exp);
        end
    endtask

    // Sends one frame and checks every cycle up to and including the done cycle.
    task automatic run_frame(input string tag, input logic [31:0] d, input int len,
                             input bit par, input bit hold_valid, input bit scramble);
        logic [32:0] bits_v;
        int          nb;
        int          ones;
        int          nframe;
        int          slot;
        int          ph;
        logic        e0;
        logic        e1;
        bits_v = '0;
        ones   = 0;
        for (int i = 0; i < len; i++) begin
            bits_v[i] = d[i];
            if (d[i]) ones++;
        end
        nb = len;
        if (par) begin
            bits_v[len] = (ones % 2 == 0);
            nb++;
        end
        tx_data      = d;
        tx_len       = 6'(len);
        tx_parity_en = par;
        tx_valid     = 1'b1;
        tick();  // accept edge
        if (!hold_valid) tx_valid = 1'b0;
        nframe = (nb + 1) * SLOT;
        for (int k = 1; k <= nframe; k++) begin
            tick();
            if (scramble && k == 40) tx_data = ~d;
            slot = (k - 1) / SLOT;
            ph   = (k - 1) % SLOT;
            e0   = 1'b1;
            e1   = 1'b1;
            if (ph < PULSE) begin
                if (slot < nb) begin
                    if (bits_v[slot]) e1 = 1'b0;
                    else e0 = 1'b0;
                end else if (slot == nb) begin
                    e0 = 1'b0;
                    e1 = 1'b0;
                end
            end
            check(tag, k, {e1, e0, (k < nframe), (k == nframe), (k == nframe), 1'b0});
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        tx_data      = '0;
        tx_len       = 6'd8;
        tx_parity_en = 1'b0;
        tx_valid     = 1'b0;
        tick();
        tick();
        check("reset", 0, 6'b110010);
        rst_n = 1'b1;
        tick();
        check("idle", 0, 6'b110010);

        // 1: 0xA5, 8 bits, no parity -> 288-cycle frame
        run_frame("a5", 32'h0000_00A5, 8, 1'b0, 1'b0, 1'b0);
        tick();
        check("a5_after", 0, 6'b110010);

        // 2: 0x0F with parity -> 9th pulse on sl1_n, done after 320 cycles
        run_frame("0f_par", 32'h0000_000F, 8, 1'b1, 1'b0, 1'b0);
        tick();

        // 3: illegal lengths
        tx_len   = 6'd7;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("len7_err", 0, 6'b110011);
        tick();
        check("len7_clr", 0, 6'b110010);
        tx_len   = 6'd33;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("len33_err", 0, 6'b110011);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("len33_idle", k, 6'b110010);
        end

        // 4: all-ones 32-bit frames back-to-back with valid held
        run_frame("ff_1", 32'hFFFF_FFFF, 32, 1'b0, 1'b1, 1'b0);
        run_frame("ff_2", 32'hFFFF_FFFF, 32, 1'b0, 1'b0, 1'b0);
        tick();

        // 5: reset during bit-3 pulse (bit 3 of 0xA5 is 0 -> sl0_n low)
        tx_data  = 32'h0000_00A5;
        tx_len   = 6'd8;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 1; k <= 100; k++) tick();
        check("bit3_low", 100, 6'b101000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset", 0, 6'b110010);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("post_reset", k, 6'b110010);
        end
        run_frame("after_rst", 32'h0000_0036, 8, 1'b1, 1'b0, 1'b0);
        tick();

        // 6: data changes mid-frame must not affect the latched word
        run_frame("scramble", 32'h1234_5678, 20, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
